iq_stream_accumulator: RTL and testbench
========================================

Name: iq_stream_accumulator

Overview:
- Streaming front-end for the readout classifier. Replaces sample buffering with on-the-fly window sums.
- After a trigger, consumes WINDOW_SIZE I/Q samples from the QICK readout AXIS and applies the pre-shift (SHIFT_M).
- Accumulates NUM_WINDOWS=2 segment sums per channel, applies the post-shift (SHIFT_N), and presents one packed feature word to the downstream LogicNet stage with a valid/ready handshake.

Parameters:
- WINDOW_SIZE, 400, samples per trigger; must be divisible by 2.
- SHIFT_M, 7, LSBs dropped from each 14-bit I/Q value.
- SHIFT_N, 1, LSBs dropped from each accumulated sum.
- TIMEOUT_CYC, 1024, max consecutive cycles without in_TVALID during accumulation; 0 disables.
- Derived, not overridable:
  - SEG = WINDOW_SIZE/2
  - IW = 14-SHIFT_M (7)
  - AW = IW + clog2(SEG) (15)
  - FW = AW-SHIFT_N (14)
  - FEAT_W = 4*FW (56)

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset.
- trigger  in  1  start pulse.
- in_TDATA  in  32  [31:18] I, [17:4] Q (14-bit two's complement), [3:0] ignored.
- in_TVALID  in  1  sample valid; no TREADY, block always accepts.
- feat_TDATA  out  FEAT_W  {q1,i1,q0,i0}, each FW signed; i0 at LSBs.
- feat_TVALID  out  1  feature valid.
- feat_TREADY  in  1  downstream accept.
- busy  out  1  high in ACCUM or OUT.
- err_timeout  out  1  one-cycle pulse on abort.
- trig_overrun  out  1  sticky; set when a trigger is ignored.
- frame_count  out  16  completed frames, wraps at 0xFFFF->0.
- Reset is ap_rst_n, asynchronous, active-low; clock is ap_clk.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators, sample_cnt and idle_cnt all 0.
- States: IDLE, ACCUM, OUT.

IDLE:
- trigger=1 -> ACCUM next cycle; clear the four accumulators, sample_cnt and idle_cnt.
- A sample with in_TVALID in the trigger cycle is not captured. The first captured sample is the first valid beat after the trigger cycle.

ACCUM:
- On each in_TVALID beat:
  - Sample value = in_TDATA[31:18+SHIFT_M] (I) or in_TDATA[17:4+SHIFT_M] (Q), signed IW, sign-extended to AW.
  - Add to window 0 if sample_cnt < SEG, else window 1.
  - sample_cnt += 1; idle_cnt cleared.
- Cycles without in_TVALID: idle_cnt += 1.
- sample_cnt reaching WINDOW_SIZE on a beat -> OUT next cycle. feat_TVALID=1 in the first OUT cycle, i.e. one cycle after the last sample.
- idle_cnt reaching TIMEOUT_CYC (when nonzero):
  - -> IDLE next cycle.
  - err_timeout pulses for one cycle.
  - No feature emitted; frame_count unchanged.

OUT:
- feat_TDATA is registered and stable while feat_TVALID=1.
- On feat_TVALID & feat_TREADY: -> IDLE next cycle, feat_TVALID drops, frame_count += 1.
- in_TVALID beats arriving in OUT or IDLE are discarded.

Arithmetic:
- Final field = acc[AW-1:SHIFT_N], i.e. arithmetic shift right, floor toward -inf.
- No saturation is needed: worst case |sum| = SEG*2^(IW-1) = 12800 fits AW=15.

Boundary cases:
- trigger while in ACCUM or OUT, including the handshake cycle: ignored, trig_overrun set. It clears only on reset.
- Reset mid-frame: immediate return to IDLE; partial sums discarded; feat_TVALID deasserts asynchronously.
- feat_TREADY held high before valid: handshake completes in the first OUT cycle.

Optional Feature:
- Macro IQ_ACCUM_ROUND_EN.
- Defined: post-shift rounds half-up, final = (acc + 2^(SHIFT_N-1)) >>> SHIFT_N, computed at AW+1 bits then truncated to FW. Overflow is impossible for legal inputs. Has no effect when SHIFT_N=0.
- Undefined: plain truncation as above.

Test Plan:
- Basic frame:
  - Stimulus: trigger, then 400 back-to-back beats with I=0x0080 (shifted +1) and Q=0x3F80 (shifted -1).
  - Response: feat_TVALID one cycle after beat 400; i0=i1=100, q0=q1=-100; frame_count=1.
- Window split and extremes:
  - Stimulus: beats 0-199 I=0x1F80 (+63); beats 200-399 I=0x2000 (-64).
  - Response: i0=6300, i1=-6400.
- Rounding:
  - Stimulus: window 0 = 199 beats I=+1 plus one beat I=0.
  - Response: i0=99 without the macro, 100 with IQ_ACCUM_ROUND_EN.
- Gaps and timeout:
  - Stimulus: with TIMEOUT_CYC=16, insert a 15-cycle TVALID gap mid-frame.
  - Response: frame completes normally.
  - Stimulus: 16-cycle gap.
  - Response: err_timeout pulse, return to IDLE, no feat_TVALID.
- Backpressure and overrun:
  - Stimulus: hold feat_TREADY=0 for 50 cycles; pulse trigger during OUT.
  - Response: feat_TDATA stable throughout; trig_overrun=1; after ready, IDLE; next trigger starts a fresh frame.
- Reset mid-frame:
  - Stimulus: deassert ap_rst_n after 150 beats, release, trigger, 400 beats of +1.
  - Response: all outputs 0 during reset; new frame i0=i1=100, with no contamination from the aborted frame.

Source files
------------

// File: rtl/iq_stream_accumulator.sv
// Streaming I/Q window accumulator: two segment sums per channel, post-shifted into one feature word.
// Optional IQ_ACCUM_ROUND_EN: round-half-up on the post-shift instead of floor truncation.
module iq_stream_accumulator #(
    parameter int WINDOW_SIZE  = 400,
    parameter int SHIFT_M      = 7,
    parameter int SHIFT_N      = 1,
    parameter int TIMEOUT_CYC  = 1024,
    localparam int SEG         = WINDOW_SIZE / 2,
    localparam int IW          = 14 - SHIFT_M,
    localparam int AW          = IW + $clog2(SEG),
    localparam int FW          = AW - SHIFT_N,
    localparam int FEAT_W      = 4 * FW
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              trigger,
    input  logic [31:0]       in_TDATA,
    input  logic              in_TVALID,
    output logic [FEAT_W-1:0] feat_TDATA,
    output logic              feat_TVALID,
    input  logic              feat_TREADY,
    output logic              busy,
    output logic              err_timeout,
    output logic              trig_overrun,
    output logic [15:0]       frame_count
);

    localparam int SCW = $clog2(WINDOW_SIZE + 1);
    localparam int ICW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [SCW-1:0] CNT_LAST   = SCW'(WINDOW_SIZE);
    localparam logic [SCW-1:0] CNT_SEG    = SCW'(SEG);
    localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT_CYC);
    localparam int ROUND_BIAS = (SHIFT_N > 0) ? (1 << (SHIFT_N - 1)) : 0;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SCW-1:0]       r_sample_cnt;
    logic [ICW-1:0]       r_idle_cnt;
    logic signed [AW-1:0] r_acc [4];
    logic signed [AW-1:0] w_acc_next [4];
    logic signed [AW-1:0] w_sample [2];
    logic [FEAT_W-1:0]    r_feat_data;
    logic [FEAT_W-1:0]    w_feat_next;
    logic                 r_feat_valid;
    logic                 r_err_timeout;
    logic                 r_trig_overrun;
    logic [15:0]          r_frame_count;

    logic w_start;
    logic w_beat;
    logic w_last_beat;
    logic w_idle_tick;
    logic w_timeout;
    logic w_handshake;
    logic w_win1;
    logic w_unused;

    // Low I/Q bits below the pre-shift and the trailing nibble are don't-cares.
    assign w_unused = ^in_TDATA;

    assign w_sample[0] = AW'($signed(in_TDATA[31:18+SHIFT_M]));
    assign w_sample[1] = AW'($signed(in_TDATA[17:4+SHIFT_M]));
    assign w_win1      = (r_sample_cnt >= CNT_SEG);

    function automatic logic [FW-1:0] post_shift(input logic signed [AW-1:0] acc);
`ifdef IQ_ACCUM_ROUND_EN
        logic signed [AW:0] wide;
        wide = {acc[AW-1], acc} + (AW+1)'(ROUND_BIAS);
        return wide[AW-1:SHIFT_N];
`else
        return acc[AW-1:SHIFT_N];
`endif
    endfunction

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_beat       = 1'b0;
        w_last_beat  = 1'b0;
        w_idle_tick  = 1'b0;
        w_timeout    = 1'b0;
        w_handshake  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_start      = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_TVALID) begin
                    w_beat = 1'b1;
                    if (r_sample_cnt + SCW'(1) == CNT_LAST) begin
                        w_last_beat  = 1'b1;
                        w_state_next = S_OUT;
                    end
                end else begin
                    w_idle_tick = 1'b1;
                    if ((TIMEOUT_CYC != 0) && (r_idle_cnt + ICW'(1) == IDLE_LIMIT)) begin
                        w_timeout    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (r_feat_valid && feat_TREADY) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Index k: window = k/2, channel = k%2 (0 = I, 1 = Q); matches the {q1,i1,q0,i0} packing.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic LANE_WIN1 = (gi >= 2);
        assign w_acc_next[gi] = (w_beat && (w_win1 == LANE_WIN1))
                              ? r_acc[gi] + w_sample[gi % 2]
                              : r_acc[gi];
        assign w_feat_next[gi*FW +: FW] = post_shift(w_acc_next[gi]);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_acc[k] <= '0;
            end
            r_sample_cnt   <= '0;
            r_idle_cnt     <= '0;
            r_feat_data    <= '0;
            r_feat_valid   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_trig_overrun <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            if (w_start) begin
                for (int k = 0; k < 4; k++) begin
                    r_acc[k] <= '0;
                end
                r_sample_cnt <= '0;
                r_idle_cnt   <= '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    r_acc[k] <= w_acc_next[k];
                end
                if (w_beat) begin
                    r_sample_cnt <= r_sample_cnt + SCW'(1);
                    r_idle_cnt   <= '0;
                end else if (w_idle_tick) begin
                    r_idle_cnt <= r_idle_cnt + ICW'(1);
                end
            end

            // The feature is captured from the sums including the final beat.
            if (w_last_beat) begin
                r_feat_data <= w_feat_next;
            end

            if (w_last_beat) begin
                r_feat_valid <= 1'b1;
            end else if (w_handshake) begin
                r_feat_valid <= 1'b0;
            end

            r_err_timeout <= w_timeout;

            if (trigger && (r_state != S_IDLE)) begin
                r_trig_overrun <= 1'b1;
            end

            if (w_handshake) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign feat_TDATA   = r_feat_data;
    assign feat_TVALID  = r_feat_valid;
    assign busy         = (r_state != S_IDLE);
    assign err_timeout  = r_err_timeout;
    assign trig_overrun = r_trig_overrun;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_iq_stream_accumulator.sv
// Randomized scoreboard bench for iq_stream_accumulator against an arithmetic window-sum model.
module tb_iq_stream_accumulator;

    localparam int WINDOW_SIZE = 400;
    localparam int SHIFT_M     = 7;
    localparam int SHIFT_N     = 1;
    localparam int TIMEOUT_CYC = 16;
    localparam int SEG         = WINDOW_SIZE / 2;
    localparam int FW          = 14;
    localparam int FEAT_W      = 4 * FW;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              trigger = 1'b0;
    logic [31:0]       in_TDATA = '0;
    logic              in_TVALID = 1'b0;
    logic [FEAT_W-1:0] feat_TDATA;
    logic              feat_TVALID;
    logic              feat_TREADY = 1'b0;
    logic              busy;
    logic              err_timeout;
    logic              trig_overrun;
    logic [15:0]       frame_count;

    iq_stream_accumulator #(
        .WINDOW_SIZE (WINDOW_SIZE),
        .SHIFT_M     (SHIFT_M),
        .SHIFT_N     (SHIFT_N),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .trigger      (trigger),
        .in_TDATA     (in_TDATA),
        .in_TVALID    (in_TVALID),
        .feat_TDATA   (feat_TDATA),
        .feat_TVALID  (feat_TVALID),
        .feat_TREADY  (feat_TREADY),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .trig_overrun (trig_overrun),
        .frame_count  (frame_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        bit                is_timeout;
        logic [FEAT_W-1:0] feat;
        logic [15:0]       fcount;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_frames = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int sample_val(input logic [13:0] raw);
        int r;
        r = $signed(raw);
        return floor_div(r, 1 << SHIFT_M);
    endfunction

    function automatic int post(input int sum);
`ifdef IQ_ACCUM_ROUND_EN
        return floor_div(sum + (1 << (SHIFT_N - 1)), 1 << SHIFT_N);
`else
        return floor_div(sum, 1 << SHIFT_N);
`endif
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Pattern 0 basic +/-1, 1 extremes, 2 rounding, 3 random, 4 all +1.
    task automatic gen(input int pattern, input int n, output logic [13:0] iv, output logic [13:0] qv);
        logic [13:0] r7;
        r7 = 14'($urandom_range(0, 127));
        iv = 14'($urandom);
        qv = 14'($urandom);
        case (pattern)
            0: begin iv = 14'h0080; qv = 14'h3F80; end
            1: iv = (n < SEG) ? (14'h1F80 | r7) : (14'h2000 | r7);
            2: if (n < SEG - 1) iv = 14'h0080 | r7; else if (n == SEG - 1) iv = r7;
            4: begin iv = 14'h0080; qv = 14'h0080; end
            default: ;
        endcase
    endtask

    task automatic reset_checks();
        check("rst_feat_TVALID", 64'(feat_TVALID), 64'd0);
        check("rst_feat_TDATA", 64'(feat_TDATA), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_timeout", 64'(err_timeout), 64'd0);
        check("rst_trig_overrun", 64'(trig_overrun), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
    endtask

    task automatic run_frame(input int pattern, input int gap_at, input int gap_len,
                             input bit rand_gaps, input int abort_at);
        int          sums [4];
        logic [13:0] iv, qv;
        logic [FEAT_W-1:0] f;
        for (int k = 0; k < 4; k++) sums[k] = 0;
        // A valid beat in the trigger cycle must not be captured.
        trigger   = 1'b1;
        in_TVALID = 1'b1;
        in_TDATA  = $urandom;
        tick();
        trigger = 1'b0;
        check("busy_accum", 64'(busy), 64'd1);
        for (int n = 0; n < WINDOW_SIZE; n++) begin
            if (n == abort_at) begin
                ap_rst_n  = 1'b0;
                in_TVALID = 1'b0;
                #1;
                reset_checks();
                exp_frames = 0;
                repeat (3) tick();
                ap_rst_n = 1'b1;
                tick();
                return;
            end
            if (n == gap_at) begin
                in_TVALID = 1'b0;
                in_TDATA  = $urandom;
                if (gap_len >= TIMEOUT_CYC)
                    exp_q.push_back('{is_timeout: 1'b1, feat: '0, fcount: '0});
                repeat (gap_len) tick();
                if (gap_len >= TIMEOUT_CYC) begin
                    repeat (3) tick();
                    check("busy_after_timeout", 64'(busy), 64'd0);
                    check("fcount_after_timeout", 64'(frame_count), 64'(exp_frames));
                    return;
                end
            end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                in_TVALID = 1'b0;
                in_TDATA  = $urandom;
                repeat ($urandom_range(1, 5)) tick();
            end
            gen(pattern, n, iv, qv);
            sums[(n >= SEG) ? 2 : 0] += sample_val(iv);
            sums[(n >= SEG) ? 3 : 1] += sample_val(qv);
            in_TDATA  = {iv, qv, 4'($urandom)};
            in_TVALID = 1'b1;
            if (n == WINDOW_SIZE - 1) begin
                for (int k = 0; k < 4; k++) f[k*FW +: FW] = FW'(post(sums[k]));
                exp_q.push_back('{is_timeout: 1'b0, feat: f, fcount: 16'(exp_frames)});
                check("valid_before_last", 64'(feat_TVALID), 64'd0);
            end
            tick();
        end
        in_TVALID = 1'b0;
        check("valid_after_last", 64'(feat_TVALID), 64'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (feat_TVALID && k < 300) begin
            tick();
            k++;
        end
        check("handshake_done", 64'(feat_TVALID), 64'd0);
        check("frame_count", 64'(frame_count), 64'(exp_frames));
    endtask

    task automatic idle_junk(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_TVALID = 1'($urandom);
            in_TDATA  = $urandom;
            tick();
        end
        in_TVALID = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every feature handshake and timeout pulse.
    logic [FEAT_W-1:0] held_data;
    bit                held = 1'b0;
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst_n) begin
            if (feat_TVALID) begin
                if (held) check("feat_stable", 64'(feat_TDATA), 64'(held_data));
                held      = 1'b1;
                held_data = feat_TDATA;
                if (feat_TREADY) begin
                    if (exp_q.size() == 0 || exp_q[0].is_timeout) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_feature: got 0x%0h, expected none", feat_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("feat_data", 64'(feat_TDATA), 64'(e.feat));
                        check("fcount_at_hs", 64'(frame_count), 64'(e.fcount));
                        exp_frames++;
                    end
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
            if (err_timeout) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_timeout) begin
                    errors++;
                    $display("FAIL unexpected_timeout: got err_timeout=1, expected 0");
                end else begin
                    void'(exp_q.pop_front());
                    $display("ok   err_timeout pulse");
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    always begin
        @(posedge ap_clk);
        #2;
        if (rand_ready) feat_TREADY = 1'($urandom);
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (3) tick();
        reset_checks();
        ap_rst_n = 1'b1;
        tick();

        // Ready held high before valid: handshake in the first OUT cycle.
        feat_TREADY = 1'b1;
        run_frame(0, -1, 0, 1'b0, -1);
        wait_done();
        idle_junk(10);

        run_frame(1, -1, 0, 1'b1, -1);
        wait_done();

        rand_ready = 1'b1;
        run_frame(2, -1, 0, 1'b1, -1);
        wait_done();
        rand_ready  = 1'b0;
        #2;
        feat_TREADY = 1'b1;

        run_frame(3, 120, TIMEOUT_CYC - 1, 1'b0, -1);
        wait_done();

        run_frame(3, 80, TIMEOUT_CYC, 1'b0, -1);
        idle_junk(5);

        // Backpressure with a trigger pulse during OUT.
        feat_TREADY = 1'b0;
        run_frame(3, -1, 0, 1'b1, -1);
        repeat (10) tick();
        check("overrun_before", 64'(trig_overrun), 64'd0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("overrun_set", 64'(trig_overrun), 64'd1);
        check("valid_held", 64'(feat_TVALID), 64'd1);
        repeat (40) tick();
        feat_TREADY = 1'b1;
        wait_done();
        check("idle_after_bp", 64'(busy), 64'd0);
        run_frame(4, -1, 0, 1'b0, -1);
        wait_done();
        check("overrun_sticky", 64'(trig_overrun), 64'd1);

        rand_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            idle_junk(int'($urandom_range(0, 6)));
            run_frame(3, -1, 0, 1'b1, -1);
            wait_done();
        end
        rand_ready  = 1'b0;
        #2;
        feat_TREADY = 1'b1;

        // Reset mid-frame, then a clean +1 frame.
        run_frame(3, -1, 0, 1'b0, 150);
        run_frame(4, -1, 0, 1'b0, -1);
        wait_done();

        repeat (5) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
